// File: rtl/opb_reg_pkg.sv
// Shared definitions for the PPC-to-Simulink OPB register: FSM states,
// register offsets inside the slave window and status word layout.
package opb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } opb_state_t;

  // Byte offsets of the two registers inside the slave window
  localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
  // Only the address bit that separates the two offsets is decoded
  localparam logic [31:0] OFS_MASK   = OFS_DATA ^ OFS_STATUS;

  // Status word layout (little-endian bit numbers of the 32-bit value)
  localparam int STAT_CNT_LSB  = 0;
  localparam int STAT_CNT_MSB  = 15;
  localparam int STAT_PEND_BIT = 16;

  // True when the address selects the status register
  function automatic logic ofs_is_status(input logic [31:0] addr);
    return (addr & OFS_MASK) != (OFS_DATA & OFS_MASK);
  endfunction

  // Assemble the read-only status word; unused bits read as zero
  function automatic logic [31:0] status_word(input logic [15:0] cnt, input logic pend);
    logic [31:0] w;
    w = '0;
    w[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
    w[STAT_PEND_BIT] = pend;
    return w;
  endfunction

endpackage

// File: rtl/opb_be_merge.sv
// Byte-enable merge for OPB writes. be[0] is the big-endian first lane,
// i.e. it selects bits [31:24] of the little-endian word.
module opb_be_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [0:3]  be,
  output logic [31:0] merged_word
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign merged_word[31-8*gi -: 8] = be[gi] ? new_word[31-8*gi -: 8]
                                                : old_word[31-8*gi -: 8];
    end
  endgenerate

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// OPB slave register written by the PPC and consumed by Simulink user logic
// on the same clock. Offset 0x0 is the byte-enabled data register, offset 0x4
// a read-only status word (write counter and pending flag).
// Optional feature: define OPB_REG_SHADOW_EN to stage PPC writes in a shadow
// register that user logic commits with user_load; without it every write
// commits straight to user_data_out.
module opb_register_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h01080400,
  parameter logic [31:0] C_HIGHADDR    = 32'h010804FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000,
  parameter              C_FAMILY      = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic                    user_load,
  output logic [31:0]             user_data_out,
  output logic                    user_data_valid
);

  opb_state_t  state_reg;
  logic        xfer_ack_reg;
  logic        err_ack_reg;
  logic [31:0] dbus_reg;

  // Request captured when the hit is accepted; the write lands in the ACK cycle
  logic        req_rnw_reg;
  logic        req_status_reg;
  logic [0:3]  req_be_reg;
  logic [31:0] req_data_reg;

  // data_reg is what the PPC sees at offset 0x0 (the shadow when staging is on)
  logic [31:0] data_reg;
  logic [15:0] wr_count_reg;
  logic [31:0] user_data_reg;
  logic        user_valid_reg;
  logic        pending;

  logic [31:0] addr;
  logic        hit;
  logic        hit_status;
  logic        write_commit;
  logic [31:0] merged_word;

  assign addr       = OPB_ABus;
  assign hit        = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign hit_status = ofs_is_status(addr);

  // Only writes to the data offset change state; status writes are error-acked
  assign write_commit = (state_reg == ACK) && !req_rnw_reg && !req_status_reg;

  opb_be_merge u_be_merge (
    .old_word    (data_reg),
    .new_word    (req_data_reg),
    .be          (req_be_reg),
    .merged_word (merged_word)
  );

  // Bus handshake: one ack per select, stretched selects parked in HOLD
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_reg      <= IDLE;
      xfer_ack_reg   <= 1'b0;
      err_ack_reg    <= 1'b0;
      dbus_reg       <= '0;
      req_rnw_reg    <= 1'b0;
      req_status_reg <= 1'b0;
      req_be_reg     <= '0;
      req_data_reg   <= '0;
    end else begin
      xfer_ack_reg <= 1'b0;
      err_ack_reg  <= 1'b0;
      dbus_reg     <= '0;
      case (state_reg)
        IDLE: begin
          if (hit) begin
            state_reg      <= ACK;
            xfer_ack_reg   <= 1'b1;
            err_ack_reg    <= !OPB_RNW && hit_status;
            if (OPB_RNW) begin
              dbus_reg <= hit_status ? status_word(wr_count_reg, pending) : data_reg;
            end
            req_rnw_reg    <= OPB_RNW;
            req_status_reg <= hit_status;
            req_be_reg     <= OPB_BE;
            req_data_reg   <= OPB_DBus;
          end
        end
        ACK:     state_reg <= HOLD;
        HOLD:    if (!OPB_select) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef OPB_REG_SHADOW_EN
  logic pending_reg;
  assign pending = pending_reg;

  // Staged writes: PPC fills the shadow, user_load hands it to user logic
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_reg       <= C_RESET_VALUE;
      wr_count_reg   <= '0;
      user_data_reg  <= C_RESET_VALUE;
      user_valid_reg <= 1'b0;
      pending_reg    <= 1'b0;
    end else begin
      user_valid_reg <= 1'b0;
      if (write_commit) begin
        data_reg     <= merged_word;
        wr_count_reg <= wr_count_reg + 16'd1;
      end
      // A load colliding with a write takes the pre-write shadow and leaves
      // pending set so the new value is still waiting to be committed
      if (user_load && pending_reg) begin
        user_data_reg  <= data_reg;
        user_valid_reg <= 1'b1;
      end
      if (write_commit) begin
        pending_reg <= 1'b1;
      end else if (user_load && pending_reg) begin
        pending_reg <= 1'b0;
      end
    end
  end
`else
  assign pending = 1'b0;

  // Direct writes: every accepted data write is committed to user logic
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_reg       <= C_RESET_VALUE;
      wr_count_reg   <= '0;
      user_data_reg  <= C_RESET_VALUE;
      user_valid_reg <= 1'b0;
    end else begin
      user_valid_reg <= 1'b0;
      if (write_commit) begin
        data_reg       <= merged_word;
        wr_count_reg   <= wr_count_reg + 16'd1;
        user_data_reg  <= merged_word;
        user_valid_reg <= 1'b1;
      end
    end
  end
`endif

  assign Sl_DBus         = dbus_reg;
  assign Sl_xferAck      = xfer_ack_reg;
  assign Sl_errAck       = err_ack_reg;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_out   = user_data_reg;
  assign user_data_valid = user_valid_reg;

  // Inputs with no function in this configuration (bursts are not supported)
  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, user_load, C_FAMILY[7:0]};

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Self-checking bench for opb_register_ppc2simulink: a table of single
// transfers plus hand-written multi-cycle sequences. Acks are checked against
// a scoreboard queue filled when each transfer is driven.
module tb_opb_register_ppc2simulink;

  localparam logic [31:0] BASE      = 32'h01080400;
  localparam logic [31:0] HIGH      = 32'h010804FF;
  localparam logic [31:0] RESET_VAL = 32'hA5A50F0F;

  logic        OPB_Clk;
  logic        OPB_Rst_n;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        user_load;
  logic [31:0] user_data_out;
  logic        user_data_valid;

  opb_register_ppc2simulink #(
    .C_BASEADDR    (BASE),
    .C_HIGHADDR    (HIGH),
    .C_RESET_VALUE (RESET_VAL)
  ) dut (
    .OPB_Clk         (OPB_Clk),
    .OPB_Rst_n       (OPB_Rst_n),
    .OPB_ABus        (OPB_ABus),
    .OPB_BE          (OPB_BE),
    .OPB_DBus        (OPB_DBus),
    .OPB_RNW         (OPB_RNW),
    .OPB_select      (OPB_select),
    .OPB_seqAddr     (OPB_seqAddr),
    .Sl_DBus         (Sl_DBus),
    .Sl_xferAck      (Sl_xferAck),
    .Sl_errAck       (Sl_errAck),
    .Sl_retry        (Sl_retry),
    .Sl_toutSup      (Sl_toutSup),
    .user_load       (user_load),
    .user_data_out   (user_data_out),
    .user_data_valid (user_data_valid)
  );

  initial OPB_Clk = 1'b0;
  always #5 OPB_Clk = ~OPB_Clk;

  typedef struct packed {
    logic [31:0] dbus;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp_dbus;
    logic        exp_err;
    logic [31:0] exp_user;
    logic        chk_valid;
    logic        exp_valid;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ack_cnt  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Ack monitor: every ack must match the oldest outstanding expectation
  always @(negedge OPB_Clk) begin
    if (Sl_xferAck === 1'b1) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack with dbus %h expected no ack at %0t", Sl_DBus, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check32("ack_dbus", Sl_DBus, e.dbus);
        check32("ack_errack", {31'd0, Sl_errAck}, {31'd0, e.err});
        check32("ack_retry_tout", {30'd0, Sl_retry, Sl_toutSup}, 32'd0);
      end
    end
  end

  // One transfer: drive, check the ack one cycle after the hit, release select.
  // Returns at the negedge of cycle N+2, where committed user data is visible.
  task automatic do_xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                         input logic [31:0] data, input logic exp_hit,
                         input logic [31:0] exp_dbus, input logic exp_err);
    @(negedge OPB_Clk);
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_BE     = be;
    OPB_DBus   = data;
    OPB_select = 1'b1;
    if (exp_hit) exp_q.push_back('{dbus: exp_dbus, err: exp_err});
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    check32("ack_latency", {31'd0, Sl_xferAck}, {31'd0, exp_hit});
    OPB_select = 1'b0;
    OPB_ABus   = '0;
    OPB_DBus   = '0;
    OPB_BE     = '0;
    OPB_RNW    = 1'b0;
    @(negedge OPB_Clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_dbus"}, Sl_DBus, 32'd0);
    check32({tag, "_acks"}, {29'd0, Sl_xferAck, Sl_errAck, Sl_retry}, 32'd0);
    check32({tag, "_user"}, user_data_out, RESET_VAL);
    check32({tag, "_valid"}, {31'd0, user_data_valid}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   a0;

    OPB_Rst_n   = 1'b0;
    OPB_ABus    = '0;
    OPB_BE      = '0;
    OPB_DBus    = '0;
    OPB_RNW     = 1'b0;
    OPB_select  = 1'b0;
    OPB_seqAddr = 1'b0;
    user_load   = 1'b0;

    repeat (3) @(negedge OPB_Clk);
    check_reset_outputs("reset");
    OPB_Rst_n = 1'b1;
    @(negedge OPB_Clk);

`ifndef OPB_REG_SHADOW_EN
    //            addr        rnw   be     data          exp_dbus      err   exp_user      chkv  expv
    vecs[0]  = '{BASE,        1'b1, 4'h0, 32'h0,        RESET_VAL,    1'b0, RESET_VAL,    1'b1, 1'b0};
    vecs[1]  = '{BASE,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    vecs[2]  = '{BASE,        1'b0, 4'h4, 32'h00AA0000, 32'h0,        1'b0, 32'hDEAABEEF, 1'b1, 1'b1};
    vecs[3]  = '{BASE,        1'b1, 4'h0, 32'h0,        32'hDEAABEEF, 1'b0, 32'hDEAABEEF, 1'b1, 1'b0};
    vecs[4]  = '{BASE + 4,    1'b1, 4'h0, 32'h0,        32'h00000002, 1'b0, 32'hDEAABEEF, 1'b1, 1'b0};
    vecs[5]  = '{BASE + 4,    1'b0, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1, 32'hDEAABEEF, 1'b1, 1'b0};
    vecs[6]  = '{BASE + 4,    1'b1, 4'h0, 32'h0,        32'h00000002, 1'b0, 32'hDEAABEEF, 1'b1, 1'b0};
    vecs[7]  = '{BASE,        1'b0, 4'h0, 32'h12345678, 32'h0,        1'b0, 32'hDEAABEEF, 1'b0, 1'b0};
    vecs[8]  = '{BASE + 4,    1'b1, 4'h0, 32'h0,        32'h00000003, 1'b0, 32'hDEAABEEF, 1'b1, 1'b0};
    vecs[9]  = '{BASE,        1'b0, 4'h9, 32'h11223344, 32'h0,        1'b0, 32'h11AABE44, 1'b1, 1'b1};
    vecs[10] = '{BASE + 'hFC, 1'b1, 4'h0, 32'h0,        32'h00000004, 1'b0, 32'h11AABE44, 1'b1, 1'b0};
    vecs[11] = '{BASE,        1'b1, 4'h0, 32'h0,        32'h11AABE44, 1'b0, 32'h11AABE44, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      do_xfer(vecs[i].addr, vecs[i].rnw, vecs[i].be, vecs[i].data, 1'b1,
              vecs[i].exp_dbus, vecs[i].exp_err);
      check32($sformatf("vec%0d_user_data", i), user_data_out, vecs[i].exp_user);
      if (vecs[i].chk_valid)
        check32($sformatf("vec%0d_valid", i), {31'd0, user_data_valid}, {31'd0, vecs[i].exp_valid});
      $display("vec %0d: addr %h rnw %0d be %h data %h -> user %h", i, vecs[i].addr,
               vecs[i].rnw, vecs[i].be, vecs[i].data, user_data_out);
    end

    // Select held for 5 cycles produces exactly one ack
    @(negedge OPB_Clk);
    OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_select = 1'b1;
    exp_q.push_back('{dbus: 32'h11AABE44, err: 1'b0});
    a0 = ack_cnt;
    repeat (5) @(negedge OPB_Clk);
    check32("stretch_ack_count", ack_cnt - a0, 32'd1);
    OPB_select = 1'b0;
    repeat (2) @(negedge OPB_Clk);
    $display("stretched select: %0d ack(s)", ack_cnt - a0);

    // One byte past the window is a miss
    a0 = ack_cnt;
    OPB_ABus = HIGH + 32'd1; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'h0BADF00D;
    OPB_select = 1'b1;
    repeat (4) @(negedge OPB_Clk);
    check32("miss_ack_count", ack_cnt - a0, 32'd0);
    check32("miss_user_data", user_data_out, 32'h11AABE44);
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    $display("miss at %h: %0d ack(s)", HIGH + 32'd1, ack_cnt - a0);

    // Counter wrap: preset near the top, then two more writes
    force dut.wr_count_reg = 16'hFFFE;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    release dut.wr_count_reg;
    do_xfer(BASE, 1'b0, 4'hF, 32'h00000000, 1'b1, 32'h0, 1'b0);
    do_xfer(BASE + 4, 1'b1, 4'h0, 32'h0, 1'b1, 32'h0000FFFF, 1'b0);
    do_xfer(BASE, 1'b0, 4'hF, 32'h00000000, 1'b1, 32'h0, 1'b0);
    do_xfer(BASE + 4, 1'b1, 4'h0, 32'h0, 1'b1, 32'h00000000, 1'b0);
    $display("wrap: status read after preset write pair");

    // Reset asserted while a write is being acked drops it
    do_xfer(BASE, 1'b0, 4'hF, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b0);
    check32("pre_reset_user", user_data_out, 32'h5A5A5A5A);
    @(negedge OPB_Clk);
    OPB_ABus = BASE; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'hCAFEF00D;
    OPB_select = 1'b1;
    exp_q.push_back('{dbus: 32'h0, err: 1'b0});
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    check32("reset_ack_cycle", {31'd0, Sl_xferAck}, 32'd1);
    #2 OPB_Rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    OPB_Rst_n = 1'b1;
    @(negedge OPB_Clk);
    do_xfer(BASE, 1'b1, 4'h0, 32'h0, 1'b1, RESET_VAL, 1'b0);
    do_xfer(BASE + 4, 1'b1, 4'h0, 32'h0, 1'b1, 32'h00000000, 1'b0);
    check32("post_reset_user", user_data_out, RESET_VAL);
    $display("reset during ack: write dropped, registers at reset values");
`else
    // Shadow staging: writes wait for user_load
    do_xfer(BASE, 1'b0, 4'hF, 32'h12345678, 1'b1, 32'h0, 1'b0);
    check32("shadow_user_held", user_data_out, RESET_VAL);
    check32("shadow_no_valid", {31'd0, user_data_valid}, 32'd0);
    do_xfer(BASE + 4, 1'b1, 4'h0, 32'h0, 1'b1, 32'h00010001, 1'b0);
    do_xfer(BASE, 1'b1, 4'h0, 32'h0, 1'b1, 32'h12345678, 1'b0);
    $display("shadow write 12345678: user %h", user_data_out);

    // user_load during the ack of a second write commits the old shadow
    @(negedge OPB_Clk);
    OPB_ABus = BASE; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'h00000000;
    OPB_select = 1'b1;
    exp_q.push_back('{dbus: 32'h0, err: 1'b0});
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    check32("collide_ack", {31'd0, Sl_xferAck}, 32'd1);
    user_load = 1'b1;
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    user_load = 1'b0;
    check32("collide_user", user_data_out, 32'h12345678);
    check32("collide_valid", {31'd0, user_data_valid}, 32'd1);
    @(negedge OPB_Clk);
    do_xfer(BASE + 4, 1'b1, 4'h0, 32'h0, 1'b1, 32'h00010002, 1'b0);
    $display("load with write: user %h", user_data_out);

    @(negedge OPB_Clk);
    user_load = 1'b1;
    @(negedge OPB_Clk);
    user_load = 1'b0;
    check32("load_user", user_data_out, 32'h00000000);
    check32("load_valid", {31'd0, user_data_valid}, 32'd1);
    do_xfer(BASE + 4, 1'b1, 4'h0, 32'h0, 1'b1, 32'h00000002, 1'b0);
    @(negedge OPB_Clk);
    user_load = 1'b1;
    @(negedge OPB_Clk);
    user_load = 1'b0;
    check32("idle_load_valid", {31'd0, user_data_valid}, 32'd0);
    $display("load: user %h", user_data_out);
`endif

    repeat (2) @(negedge OPB_Clk);
    check32("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
